// File: rtl/bpsk_pkg.sv
// Shared types for the BPSK symbol correlator: accumulator width helper,
// FIFO entry layout and correlator FSM states.
// Optional macro BPSK_SOFT_OUT_EN adds the signed soft sum to each FIFO entry.
package bpsk_pkg;

    // Soft sum storage; the top slices its own ACC_W bits out of this field.
    localparam int SOFT_MAX_W = 48;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Product is 2*DW+1 bits; summing SPS of them adds clog2(SPS) bits of growth.
    function automatic int acc_width(input int data_width, input int sps);
        return 2 * data_width + 1 + $clog2(sps);
    endfunction

    typedef struct packed {
        logic hard;
        logic erasure;
`ifdef BPSK_SOFT_OUT_EN
        logic signed [SOFT_MAX_W-1:0] soft;
`endif
    } sym_entry_t;

endpackage

// File: rtl/bpsk_ref_rom.sv
// Registered sine reference LUT, one full carrier period of SPS entries.
// Latency: 1 cycle from addr to data. No backpressure (free-running read).
// Ports: clk, addr (reference index), data (signed DATA_WIDTH sine sample).
module bpsk_ref_rom #(
    parameter int DATA_WIDTH = 8,
    parameter int SPS        = 32,
    localparam int IDX_W     = $clog2(SPS)
) (
    input  logic                         clk,
    input  logic [IDX_W-1:0]             addr,
    output logic signed [DATA_WIDTH-1:0] data
);

    localparam real PI  = 3.14159265358979323846;
    localparam real AMP = (2.0 ** (DATA_WIDTH - 1)) - 1.0;

    logic signed [DATA_WIDTH-1:0] lut [SPS];

    // Table values are fixed at elaboration; rounding is half away from zero.
    for (genvar k = 0; k < SPS; k++) begin : g_lut
        localparam real X = AMP * $sin(2.0 * PI * k / SPS);
        localparam int  V = (X >= 0.0) ? $rtoi(X + 0.5) : -$rtoi(0.5 - X);
        assign lut[k] = DATA_WIDTH'(V);
    end

    always_ff @(posedge clk) begin
        data <= lut[addr];
    end

endmodule

// File: rtl/bpsk_symbol_correlator.sv
// BPSK front end: correlates offset-binary samples with a sine reference per symbol, decides bit + erasure.
// Latency: decision visible on sym_valid 3 cycles after the final sample of a symbol is presented.
// Backpressure: FIFO_DEPTH-entry output queue; a decision arriving while full is dropped and sets sticky overflow.
// Ports: clk, reset (sync, active-high), enable, phase_ofs, sample/sample_valid in;
//        sym_valid/sym_ready handshake, sym_bit, sym_erasure, overflow out (+ sym_soft with BPSK_SOFT_OUT_EN).
module bpsk_symbol_correlator
    import bpsk_pkg::*;
#(
    parameter int DATA_WIDTH         = 8,
    parameter int SAMPLES_PER_SYMBOL = 32,
    parameter int OFFSET             = 128,
    parameter int THRESHOLD          = 1024,
    parameter int FIFO_DEPTH         = 4,
    localparam int IDX_W             = $clog2(SAMPLES_PER_SYMBOL),
    localparam int ACC_W             = acc_width(DATA_WIDTH, SAMPLES_PER_SYMBOL)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [IDX_W-1:0]        phase_ofs,
    input  logic [DATA_WIDTH-1:0]   sample,
    input  logic                    sample_valid,
    output logic                    sym_valid,
    input  logic                    sym_ready,
    output logic                    sym_bit,
    output logic                    sym_erasure,
    output logic                    overflow
`ifdef BPSK_SOFT_OUT_EN
    ,
    output logic signed [ACC_W-1:0] sym_soft
`endif
);

    localparam int PROD_W = 2 * DATA_WIDTH + 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(SAMPLES_PER_SYMBOL - 1);
    localparam logic signed [ACC_W-1:0] ZERO     = '0;
    localparam logic signed [ACC_W-1:0] THR_POS  = ACC_W'(THRESHOLD);
    localparam logic signed [ACC_W-1:0] THR_NEG  = ACC_W'(-THRESHOLD);

    // ---------------- control FSM: reference index and sample count ----------------
    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] count;
    logic             accept;
    logic             abort;

    assign accept = (state == RUN) && enable && sample_valid;
    assign abort  = (state == RUN) && !enable;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= RUN;
                        idx   <= phase_ofs;
                        count <= '0;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (sample_valid) begin
                        idx   <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                        count <= (count == LAST_IDX) ? '0 : count + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---------------- stage 1: sample register alongside the ROM read ----------------
    logic signed [DATA_WIDTH-1:0] ref_val;
    logic [DATA_WIDTH-1:0]        s1_sample;
    logic                         s1_vld;
    logic                         s1_last;

    bpsk_ref_rom #(
        .DATA_WIDTH (DATA_WIDTH),
        .SPS        (SAMPLES_PER_SYMBOL)
    ) u_ref_rom (
        .clk  (clk),
        .addr (idx),
        .data (ref_val)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld    <= 1'b0;
            s1_last   <= 1'b0;
            s1_sample <= '0;
        end else begin
            s1_vld    <= accept;
            s1_last   <= (count == LAST_IDX);
            s1_sample <= sample;
        end
    end

    // ---------------- stage 2: multiply / accumulate ----------------
    logic signed [DATA_WIDTH:0] centred;
    logic signed [PROD_W-1:0]   product;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    sum_next;
    logic signed [ACC_W-1:0]    sum_reg;
    logic                       sum_vld;

    assign centred  = $signed({1'b0, s1_sample}) - $signed((DATA_WIDTH + 1)'(OFFSET));
    assign product  = PROD_W'(centred) * PROD_W'(ref_val);
    assign sum_next = acc + ACC_W'(product);

    // An abort also kills the sample still sitting in stage 1, so no partial symbol survives.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            sum_reg <= '0;
            sum_vld <= 1'b0;
        end else begin
            sum_vld <= 1'b0;
            if (abort) begin
                acc <= '0;
            end else if (s1_vld) begin
                if (s1_last) begin
                    sum_reg <= sum_next;
                    sum_vld <= 1'b1;
                    acc     <= '0;
                end else begin
                    acc <= sum_next;
                end
            end
        end
    end

    // ---------------- decision + output FIFO ----------------
    sym_entry_t       push_entry;
    sym_entry_t       head;
    sym_entry_t       mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             empty;
    logic             full;
    logic             pop;
    logic             do_push;

    always_comb begin
        push_entry         = '0;
        push_entry.hard    = (sum_reg > ZERO);
        push_entry.erasure = (sum_reg <= THR_POS) && (sum_reg >= THR_NEG);
`ifdef BPSK_SOFT_OUT_EN
        push_entry.soft    = SOFT_MAX_W'(sum_reg);
`endif
    end

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop     = !empty && sym_ready;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_push = sum_vld && (!full || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (sum_vld && !do_push) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_entry;
    end

    // Outputs are forced low while empty so stale entries never show.
    assign head        = mem[rd_ptr[PTR_W-1:0]];
    assign sym_valid   = !empty;
    assign sym_bit     = sym_valid & head.hard;
    assign sym_erasure = sym_valid & head.erasure;
`ifdef BPSK_SOFT_OUT_EN
    assign sym_soft    = sym_valid ? $signed(head.soft[ACC_W-1:0]) : ZERO;
`endif

endmodule

// File: tb/tb_bpsk_symbol_correlator.sv
// Self-checking bench for bpsk_symbol_correlator: randomized waveforms and valid gaps,
// expected decisions from a plain dot-product model pushed to a queue, checked by a monitor.
// With BPSK_SOFT_OUT_EN the soft sum is also compared.
module tb_bpsk_symbol_correlator;

    localparam int DW    = 8;
    localparam int SPS   = 32;
    localparam int OFS   = 128;
    localparam int THR   = 1024;
    localparam int DEPTH = 4;
    localparam int ACC_W = 2 * DW + 1 + $clog2(SPS);

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [4:0] phase_ofs;
    logic [7:0] sample;
    logic       sample_valid;
    logic       sym_valid;
    logic       sym_ready;
    logic       sym_bit;
    logic       sym_erasure;
    logic       overflow;
`ifdef BPSK_SOFT_OUT_EN
    logic signed [ACC_W-1:0] sym_soft;
`endif

    always #5 clk = ~clk;

    bpsk_symbol_correlator dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .phase_ofs    (phase_ofs),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sym_valid    (sym_valid),
        .sym_ready    (sym_ready),
        .sym_bit      (sym_bit),
        .sym_erasure  (sym_erasure),
        .overflow     (overflow)
`ifdef BPSK_SOFT_OUT_EN
        ,
        .sym_soft     (sym_soft)
`endif
    );

    typedef struct {
        bit     b;
        bit     e;
        longint sum;
    } exp_t;

    exp_t   exp_q[$];
    int     compared   = 0;
    int     mismatched = 0;
    int     cyc        = 0;
    int     ref_tab[SPS];
    int     wave[SPS];
    int     exp_rise   = 0;
    bit     lat_armed  = 1'b0;
    bit     model_ovf  = 1'b0;
    logic   prev_vld   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic signed [63:0] act, input longint exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare the FIFO head against the model queue whenever it is presented.
    always @(negedge clk) begin
        if (!reset) begin
            if (sym_valid && !prev_vld && lat_armed) begin
                chk("latency_cycle", cyc, exp_rise);
                lat_armed = 1'b0;
            end
            if (sym_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_symbol", 1, 0);
                end else begin
                    chk("sym_bit", sym_bit, exp_q[0].b);
                    chk("sym_erasure", sym_erasure, exp_q[0].e);
`ifdef BPSK_SOFT_OUT_EN
                    chk("sym_soft", sym_soft, exp_q[0].sum);
`endif
                    if (sym_ready) void'(exp_q.pop_front());
                end
            end
        end
        prev_vld = sym_valid;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        sample_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic start(input int ph);
        enable       = 1'b1;
        phase_ofs    = 5'(ph);
        sample_valid = 1'b0;
        tick();
    endtask

    task automatic set_shifted(input int shift, input int sign);
        for (int i = 0; i < SPS; i++) wave[i] = OFS + sign * ref_tab[(i + shift) % SPS];
    endtask

    // Drives one symbol from wave[]; the model computes the correlation directly.
    task automatic run_symbol(input int ph, input int gap_pct, input bit arm);
        longint sum = 0;
        exp_t   e;
        for (int i = 0; i < SPS; i++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                sample_valid = 1'b0;
                sample       = 8'($urandom);
                tick();
            end
            sample       = 8'(wave[i]);
            sample_valid = 1'b1;
            sum += longint'((wave[i] - OFS) * ref_tab[(ph + i) % SPS]);
            if (i == SPS - 1) begin
                e.sum = sum;
                e.b   = (sum > 0);
                e.e   = (sum <= THR) && (sum >= -THR);
                if (exp_q.size() < DEPTH) exp_q.push_back(e);
                else model_ovf = 1'b1;
                exp_rise  = cyc + 3;
                lat_armed = arm;
            end
            tick();
        end
        sample_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick();
        chk("drain_remaining", exp_q.size(), 0);
    endtask

    initial begin
        reset        = 1'b1;
        enable       = 1'b0;
        phase_ofs    = '0;
        sample       = 8'd128;
        sample_valid = 1'b0;
        sym_ready    = 1'b1;
        for (int k = 0; k < SPS; k++) begin
            real x;
            x = 127.0 * $sin(2.0 * 3.141592653589793 * k / SPS);
            ref_tab[k] = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
        end
        repeat (3) tick();
        chk("reset_sym_valid", sym_valid, 0);
        chk("reset_sym_bit", sym_bit, 0);
        chk("reset_sym_erasure", sym_erasure, 0);
        chk("reset_overflow", overflow, 0);
        reset = 1'b0;
        tick();

        // In-phase symbols, back to back, consumer always ready.
        start(0);
        for (int s = 0; s < 3; s++) begin
            set_shifted(0, 1);
            run_symbol(0, 0, 1'b0);
        end

        // Inverted waveform, then mid-scale constant (zero sum).
        set_shifted(0, -1);
        run_symbol(0, 0, 1'b0);
        for (int i = 0; i < SPS; i++) wave[i] = OFS;
        run_symbol(0, 0, 1'b0);

        // Random sample_valid gaps; also checks decision latency.
        for (int s = 0; s < 3; s++) begin
            set_shifted(0, 1);
            run_symbol(0, 50, 1'b1);
            idle(5);
        end
        wait_drain();

        // Consumer stalled for 6 random symbols: 4 queue, the rest overflow.
        sym_ready = 1'b0;
        for (int s = 0; s < 6; s++) begin
            for (int i = 0; i < SPS; i++) wave[i] = $urandom_range(255);
            run_symbol(0, 0, 1'b0);
            idle(5);
            chk("overflow_after_symbol", overflow, model_ovf);
        end
        sym_ready = 1'b1;
        wait_drain();
        idle(2);
        chk("sym_valid_after_release", sym_valid, 0);

        // Abort after 10 samples, restart at phase 8 with quadrature-shifted input.
        set_shifted(0, 1);
        for (int i = 0; i < 10; i++) begin
            sample       = 8'(wave[i]);
            sample_valid = 1'b1;
            tick();
        end
        enable = 1'b0;
        sample = 8'(wave[10]);
        tick();
        sample_valid = 1'b0;
        tick();
        start(8);
        set_shifted(8, 1);
        run_symbol(8, 0, 1'b0);
        idle(6);
        wait_drain();

        // Reset coinciding with the final sample of a symbol.
        set_shifted(8, 1);
        for (int i = 0; i < SPS - 1; i++) begin
            sample       = 8'(wave[i]);
            sample_valid = 1'b1;
            tick();
        end
        sample = 8'(wave[SPS-1]);
        reset  = 1'b1;
        tick();
        reset        = 1'b0;
        enable       = 1'b0;
        sample_valid = 1'b0;
        model_ovf    = 1'b0;
        idle(8);
        chk("post_reset_sym_valid", sym_valid, 0);
        chk("post_reset_overflow", overflow, model_ovf);
        chk("post_reset_queue", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
